// File: rtl/id_ex_if.sv
// id_ex_if: groups every non-clock/reset signal of the ID/EX stage.
//   ID side     : id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1,
//                 id_rs2, id_rd, id_alu_ctr, id_src_a_pc, id_src_b_imm,
//                 id_reg_we, id_mem_re, id_mem_we
//   pipe control: stall, flush
//   bypass      : mem_reg_we, mem_rd, mem_result, wb_reg_we, wb_rd, wb_result
//   EX side     : ex_valid, ex_pc, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we,
//                 alu_a, alu_b, alu_ctr, ex_store_data, load_use
// Modport slave is the stage itself; master is whoever drives ID and
// observes EX (the surrounding core or a bench).
interface id_ex_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [RA_W-1:0] id_rd;
  logic [2:0]      id_alu_ctr;
  logic            id_src_a_pc;
  logic            id_src_b_imm;
  logic            id_reg_we;
  logic            id_mem_re;
  logic            id_mem_we;
  logic            stall;
  logic            flush;
  logic            mem_reg_we;
  logic [RA_W-1:0] mem_rd;
  logic [XLEN-1:0] mem_result;
  logic            wb_reg_we;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_result;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_we;
  logic            ex_mem_re;
  logic            ex_mem_we;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [2:0]      alu_ctr;
  logic [XLEN-1:0] ex_store_data;
  logic            load_use;

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_alu_ctr, id_src_a_pc, id_src_b_imm, id_reg_we, id_mem_re,
           id_mem_we, stall, flush, mem_reg_we, mem_rd, mem_result, wb_reg_we,
           wb_rd, wb_result,
    output ex_valid, ex_pc, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we, alu_a,
           alu_b, alu_ctr, ex_store_data, load_use
  );

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_alu_ctr, id_src_a_pc, id_src_b_imm, id_reg_we, id_mem_re,
           id_mem_we, stall, flush, mem_reg_we, mem_rd, mem_result, wb_reg_we,
           wb_rd, wb_result,
    input  ex_valid, ex_pc, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we, alu_a,
           alu_b, alu_ctr, ex_store_data, load_use
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-side operand forwarding and
// load-use detection.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - id_ex_if.slave: ID fields in, stall/flush in, MEM/WB bypass in,
//          ALU operands / EX control / load_use out
// Pipeline control: one instruction moves ID->EX per clock. Update priority
// is rst > flush > stall > load_use > capture. flush and load_use load a
// bubble; stall holds everything (including a bubble). load_use is purely
// combinational and independent of stall/flush; ID/IF must hold while it is
// asserted so the instruction is re-presented after the bubble.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic     clk,
  input logic     rst,
  id_ex_if.slave  bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [2:0]      alu_ctr;
    logic            src_a_pc;
    logic            src_b_imm;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
  } ex_regs_t;

  ex_regs_t        ex_q, ex_d, id_fields;
  logic            load_use;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  always_comb begin
    id_fields           = '0;
    id_fields.valid     = bus.id_valid;
    id_fields.pc        = bus.id_pc;
    id_fields.rs1_data  = bus.id_rs1_data;
    id_fields.rs2_data  = bus.id_rs2_data;
    id_fields.imm       = bus.id_imm;
    id_fields.rs1       = bus.id_rs1;
    id_fields.rs2       = bus.id_rs2;
    id_fields.rd        = bus.id_rd;
    id_fields.alu_ctr   = bus.id_alu_ctr;
    id_fields.src_a_pc  = bus.id_src_a_pc;
    id_fields.src_b_imm = bus.id_src_b_imm;
    id_fields.reg_we    = bus.id_reg_we;
    id_fields.mem_re    = bus.id_mem_re;
    id_fields.mem_we    = bus.id_mem_we;
  end

  // A load in EX whose result the ID instruction needs cannot be bypassed in
  // time; x0 is excluded since it is never really written.
  assign load_use = ex_q.valid & ex_q.mem_re & (ex_q.rd != '0) &
                    ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));

  // A bubble is all-zero: invalid, no control bits, alu_ctr=000.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush)      ex_d = '0;
    else if (bus.stall) ex_d = ex_q;
    else if (load_use)  ex_d = '0;
    else                ex_d = id_fields;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  // MEM result is younger than WB, so it wins when both target rsN.
  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    if (bus.mem_reg_we && bus.mem_rd != '0 && bus.mem_rd == ex_q.rs1)
      fwd_rs1 = bus.mem_result;
    else if (bus.wb_reg_we && bus.wb_rd != '0 && bus.wb_rd == ex_q.rs1)
      fwd_rs1 = bus.wb_result;
  end

  always_comb begin
    fwd_rs2 = ex_q.rs2_data;
    if (bus.mem_reg_we && bus.mem_rd != '0 && bus.mem_rd == ex_q.rs2)
      fwd_rs2 = bus.mem_result;
    else if (bus.wb_reg_we && bus.wb_rd != '0 && bus.wb_rd == ex_q.rs2)
      fwd_rs2 = bus.wb_result;
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rd         = ex_q.rd;
  // Side-effect bits are gated so a bubble can never write anything.
  assign bus.ex_reg_we     = ex_q.valid & ex_q.reg_we;
  assign bus.ex_mem_re     = ex_q.valid & ex_q.mem_re;
  assign bus.ex_mem_we     = ex_q.valid & ex_q.mem_we;
  assign bus.alu_a         = ex_q.src_a_pc  ? ex_q.pc  : fwd_rs1;
  assign bus.alu_b         = ex_q.src_b_imm ? ex_q.imm : fwd_rs2;
  assign bus.alu_ctr       = ex_q.alu_ctr;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.load_use      = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  id_ex_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bypass();
    bus.mem_reg_we = 1'b0; bus.mem_rd = '0; bus.mem_result = '0;
    bus.wb_reg_we  = 1'b0; bus.wb_rd  = '0; bus.wb_result  = '0;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [4:0] rd, input logic [31:0] imm,
                          input logic [2:0] ctr, input logic sa,
                          input logic sb, input logic we,
                          input logic re, input logic mw);
    bus.id_valid = v;     bus.id_pc = pc;
    bus.id_rs1 = rs1;     bus.id_rs1_data = d1;
    bus.id_rs2 = rs2;     bus.id_rs2_data = d2;
    bus.id_rd = rd;       bus.id_imm = imm;
    bus.id_alu_ctr = ctr; bus.id_src_a_pc = sa; bus.id_src_b_imm = sb;
    bus.id_reg_we = we;   bus.id_mem_re = re;   bus.id_mem_we = mw;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    clear_bypass();
    drive_id(1, 32'h100, 1, 32'd10, 2, 32'd20, 3, 0, 3'b010, 0, 0, 1, 0, 0);

    // reset: 2 cycles, id_valid held high to show reset dominates
    step();
    step();
    check("rst ex_valid", {31'b0, bus.ex_valid}, 0);
    check("rst ex_pc", bus.ex_pc, 0);
    check("rst alu_a", bus.alu_a, 0);
    check("rst alu_b", bus.alu_b, 0);
    check("rst alu_ctr", {29'b0, bus.alu_ctr}, 0);
    check("rst ex_reg_we", {31'b0, bus.ex_reg_we}, 0);
    check("rst store", bus.ex_store_data, 0);
    check("rst load_use", {31'b0, bus.load_use}, 0);

    // first add captured with 1-cycle latency
    rst = 1'b0;
    step();
    check("add ex_valid", {31'b0, bus.ex_valid}, 1);
    check("add ex_pc", bus.ex_pc, 32'h100);
    check("add ex_rd", {27'b0, bus.ex_rd}, 3);
    check("add alu_a", bus.alu_a, 32'd10);
    check("add alu_b", bus.alu_b, 32'd20);
    check("add alu_ctr", {29'b0, bus.alu_ctr}, 3'b010);
    check("add ex_reg_we", {31'b0, bus.ex_reg_we}, 1);

    // MEM forward onto rs1
    drive_id(1, 32'h104, 3, 32'h11, 4, 32'h22, 6, 0, 3'b010, 0, 0, 1, 0, 0);
    step();
    bus.mem_reg_we = 1'b1; bus.mem_rd = 5'd3; bus.mem_result = 32'h55;
    #1;
    check("fwd mem alu_a", bus.alu_a, 32'h55);
    check("fwd mem alu_b", bus.alu_b, 32'h22);
    check("fwd mem load_use", {31'b0, bus.load_use}, 0);
    clear_bypass();
    #1;
    check("nofwd alu_a", bus.alu_a, 32'h11);

    // MEM beats WB; WB alone; x0 never forwarded
    drive_id(1, 32'h108, 8, 32'h80, 5, 32'h50, 9, 0, 3'b110, 0, 0, 1, 0, 0);
    step();
    bus.mem_reg_we = 1'b1; bus.mem_rd = 5'd5; bus.mem_result = 32'd1;
    bus.wb_reg_we  = 1'b1; bus.wb_rd  = 5'd5; bus.wb_result  = 32'd2;
    #1;
    check("prio alu_b", bus.alu_b, 32'd1);
    check("prio store", bus.ex_store_data, 32'd1);
    bus.mem_reg_we = 1'b0;
    #1;
    check("wb alu_b", bus.alu_b, 32'd2);
    bus.mem_reg_we = 1'b1; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
    #1;
    check("rd0 alu_b", bus.alu_b, 32'h50);
    bus.wb_rd = 5'd8; bus.wb_result = 32'h1234;
    #1;
    check("wb alu_a", bus.alu_a, 32'h1234);
    clear_bypass();

    drive_id(1, 32'h10c, 0, 32'h0, 0, 32'h99, 11, 0, 3'b010, 0, 0, 1, 0, 0);
    step();
    bus.mem_reg_we = 1'b1; bus.mem_rd = 5'd0; bus.mem_result = 32'hdead;
    #1;
    check("x0 alu_b", bus.alu_b, 32'h99);
    clear_bypass();

    // load-use: load rd=7 then consumer rs2=7
    drive_id(1, 32'h110, 1, 32'h1, 2, 32'h2, 7, 0, 3'b010, 0, 1, 1, 1, 0);
    step();
    check("ld ex_mem_re", {31'b0, bus.ex_mem_re}, 1);
    drive_id(1, 32'h114, 0, 32'h0, 7, 32'h3, 12, 0, 3'b110, 0, 0, 1, 0, 0);
    #1;
    check("lu asserted", {31'b0, bus.load_use}, 1);
    step();
    check("lu bubble valid", {31'b0, bus.ex_valid}, 0);
    check("lu bubble we", {31'b0, bus.ex_reg_we}, 0);
    check("lu bubble ctr", {29'b0, bus.alu_ctr}, 0);
    check("lu cleared", {31'b0, bus.load_use}, 0);
    step();
    check("lu replay valid", {31'b0, bus.ex_valid}, 1);
    check("lu replay ctr", {29'b0, bus.alu_ctr}, 3'b110);
    check("lu replay pc", bus.ex_pc, 32'h114);

    // load to x0 is not a hazard
    drive_id(1, 32'h118, 1, 32'h1, 2, 32'h2, 0, 0, 3'b010, 0, 1, 1, 1, 0);
    step();
    drive_id(1, 32'h11c, 0, 32'h0, 0, 32'h0, 4, 0, 3'b010, 0, 0, 1, 0, 0);
    #1;
    check("lu x0", {31'b0, bus.load_use}, 0);

    // stall holds for 3 cycles, then stall+flush loads a bubble
    drive_id(1, 32'h200, 1, 32'h7, 2, 32'h8, 10, 0, 3'b111, 0, 0, 1, 0, 0);
    step();
    drive_id(1, 32'h300, 4, 32'h9, 5, 32'ha, 13, 0, 3'b010, 0, 0, 0, 0, 1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall pc", bus.ex_pc, 32'h200);
      check("stall ctr", {29'b0, bus.alu_ctr}, 3'b111);
      check("stall rd", {27'b0, bus.ex_rd}, 10);
    end
    check("stall we", {31'b0, bus.ex_reg_we}, 1);
    check("stall mem_we", {31'b0, bus.ex_mem_we}, 0);
    bus.flush = 1'b1;
    step();
    check("flush valid", {31'b0, bus.ex_valid}, 0);
    check("flush we", {31'b0, bus.ex_reg_we}, 0);
    check("flush ctr", {29'b0, bus.alu_ctr}, 0);
    bus.flush = 1'b0;
    step();
    check("stall bubble held", {31'b0, bus.ex_valid}, 0);

    // reset mid-stall
    bus.stall = 1'b0;
    step();
    check("pre-rst valid", {31'b0, bus.ex_valid}, 1);
    bus.stall = 1'b1;
    rst = 1'b1;
    step();
    check("rst-stall valid", {31'b0, bus.ex_valid}, 0);
    rst = 1'b0;
    step();
    check("rst-stall held", {31'b0, bus.ex_valid}, 0);
    check("rst-stall pc", bus.ex_pc, 0);
    bus.stall = 1'b0;

    // PC / immediate operand select, store data bypass
    drive_id(1, 32'h400, 1, 32'h5, 2, 32'h33, 0, 32'd4, 3'b010, 1, 1, 0, 0, 1);
    step();
    check("sel alu_a", bus.alu_a, 32'h400);
    check("sel alu_b", bus.alu_b, 32'd4);
    check("sel store", bus.ex_store_data, 32'h33);
    check("sel mem_we", {31'b0, bus.ex_mem_we}, 1);
    bus.mem_reg_we = 1'b1; bus.mem_rd = 5'd2; bus.mem_result = 32'hab;
    #1;
    check("sel fwd store", bus.ex_store_data, 32'hab);
    check("sel fwd alu_b", bus.alu_b, 32'd4);
    clear_bypass();

    // invalid ID instruction produces gated control
    drive_id(0, 32'h500, 1, 32'h1, 2, 32'h2, 3, 0, 3'b010, 0, 0, 1, 1, 1);
    step();
    check("inv valid", {31'b0, bus.ex_valid}, 0);
    check("inv reg_we", {31'b0, bus.ex_reg_we}, 0);
    check("inv mem_re", {31'b0, bus.ex_mem_re}, 0);
    check("inv mem_we", {31'b0, bus.ex_mem_we}, 0);

    // final report
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
